// File: rtl/fifo_ctrl.sv
// fifo_ctrl: head/tail/occupancy control for an 8-entry FIFO built from a
// one-hot-enabled register array followed by an 8:1 read mux. The block
// drives the array write enables and the mux select. It reports
// acknowledge/error status one cycle after each request.
module fifo_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic [7:0] we,
  output logic [2:0] rd_addr,
  output logic       rd_fire,
  output logic [3:0] data_count,
  output logic       full,
  output logic       empty,
  output logic       wr_ack,
  output logic       wr_err,
  output logic       rd_ack,
  output logic       rd_err
);

  localparam logic [2:0] INIT     = 3'd0;
  localparam logic [2:0] NO_OP    = 3'd1;
  localparam logic [2:0] WRITE    = 3'd2;
  localparam logic [2:0] READ     = 3'd3;
  localparam logic [2:0] WR_RD    = 3'd4;
  localparam logic [2:0] WR_ERR   = 3'd5;
  localparam logic [2:0] RD_ERR   = 3'd6;
  localparam logic [2:0] WRRD_ERR = 3'd7;

  logic [2:0] head;
  logic [2:0] tail;
  logic [3:0] count;
  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       wr_won;
  logic       wacc;
  logic       racc;

  // Occupancy flags come from the registered count. A read in the same
  // cycle therefore never makes room for a write while the FIFO is full.
  assign full       = (count == 4'd8);
  assign empty      = (count == 4'd0);
  assign data_count = count;
  assign rd_addr    = head;

  assign wacc    = wr_en & ~full;
  assign racc    = rd_en & ~empty;
  assign rd_fire = racc & reset_n;

  // One-hot write enable at the tail slot; forced off while in reset
  always_comb begin
    we = 8'h00;
    if (reset_n && wacc) we[tail] = 1'b1;
  end

  // Classify this cycle's requests into the status state reported next cycle
  always_comb begin
    state_nxt = NO_OP;
    case ({wr_en, rd_en})
      2'b10:   state_nxt = wacc ? WRITE : WR_ERR;
      2'b01:   state_nxt = racc ? READ : RD_ERR;
      2'b11:   state_nxt = (wacc && racc) ? WR_RD : WRRD_ERR;
      default: state_nxt = NO_OP;
    endcase
  end

  // Pointer, occupancy and status-state registers. Reset wins over requests.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head   <= 3'd0;
      tail   <= 3'd0;
      count  <= 4'd0;
      state  <= INIT;
      wr_won <= 1'b0;
    end else begin
      tail   <= tail + {2'b00, wacc};
      head   <= head + {2'b00, racc};
      count  <= count + {3'b000, wacc} - {3'b000, racc};
      state  <= state_nxt;
      wr_won <= wacc;
    end
  end

  // Status decode; in WRRD_ERR, wr_won tells which side was accepted
  always_comb begin
    wr_ack = (state == WRITE) || (state == WR_RD) || ((state == WRRD_ERR) && wr_won);
    wr_err = (state == WR_ERR) || ((state == WRRD_ERR) && !wr_won);
    rd_ack = (state == READ) || (state == WR_RD) || ((state == WRRD_ERR) && !wr_won);
    rd_err = (state == RD_ERR) || ((state == WRRD_ERR) && wr_won);
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl. It includes a behavioural model of the
// 8x32 register array and the output data register, so data ordering can
// be checked alongside the control outputs.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] we;
  logic [2:0] rd_addr;
  logic       rd_fire;
  logic [3:0] data_count;
  logic       full, empty, wr_ack, wr_err, rd_ack, rd_err;

  logic [31:0] d_in;
  logic [31:0] mem [8];
  logic [31:0] dout;
  logic [31:0] exp_q [$];
  logic [31:0] wdata;

  int    n_cmp = 0;
  int    n_err = 0;
  string ph    = "init";

  fifo_ctrl dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en),
    .we(we), .rd_addr(rd_addr), .rd_fire(rd_fire), .data_count(data_count),
    .full(full), .empty(empty), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  // Storage array and output register driven by the DUT's controls
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (we[i]) mem[i] <= d_in;
    if (rd_fire) dout <= mem[rd_addr];
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s got=%0h exp=%0h", ph, tag, got, exp);
    end
  endtask

  // One request cycle: drive at negedge, check combinational outputs,
  // then step past the rising edge and check the read data if a read fired.
  task automatic op(input logic wr, input logic rd, input logic [7:0] e_we,
                    input logic [2:0] e_addr, input logic e_fire);
    logic [31:0] e_dat;
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    d_in  = wdata;
    if (wr) wdata = wdata + 32'd1;
    #1;
    chk_eq("we", {24'd0, we}, {24'd0, e_we});
    chk_eq("rd_addr", {29'd0, rd_addr}, {29'd0, e_addr});
    chk_eq("rd_fire", {31'd0, rd_fire}, {31'd0, e_fire});
    if (e_we != 8'h00) exp_q.push_back(d_in);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (e_fire) begin
      e_dat = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk_eq("dout", dout, e_dat);
    end
  endtask

  // Registered status after the most recent edge
  task automatic st(input logic wa, input logic we_, input logic ra, input logic re,
                    input int cnt);
    chk_eq("data_count", {28'd0, data_count}, cnt);
    chk_eq("full", {31'd0, full}, {31'd0, (cnt == 8)});
    chk_eq("empty", {31'd0, empty}, {31'd0, (cnt == 0)});
    chk_eq("status", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, {28'd0, wa, we_, ra, re});
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b1;
    rd_en   = 1'b0;
    d_in    = 32'd0;
    wdata   = 32'h100;

    // Reset held two cycles with a write pending
    repeat (2) @(posedge clk);
    #1;
    chk_eq("we_in_reset", {24'd0, we}, 32'd0);
    chk_eq("rd_addr_reset", {29'd0, rd_addr}, 32'd0);
    chk_eq("rd_fire_reset", {31'd0, rd_fire}, 32'd0);
    st(0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wr_en   = 1'b0;

    ph = "fill";
    for (int i = 0; i < 8; i++) begin
      op(1, 0, 8'h01 << i, 3'd0, 0);
      st(1, 0, 0, 0, i + 1);
    end
    op(1, 0, 8'h00, 3'd0, 0);
    st(0, 1, 0, 0, 8);

    ph = "drain";
    for (int i = 0; i < 8; i++) begin
      op(0, 1, 8'h00, 3'(i), 1);
      st(0, 0, 1, 0, 7 - i);
    end
    op(0, 1, 8'h00, 3'd0, 0);
    st(0, 0, 0, 1, 0);

    ph = "wrap";
    for (int i = 0; i < 5; i++) begin
      op(1, 0, 8'h01 << i, 3'd0, 0);
      st(1, 0, 0, 0, i + 1);
    end
    for (int i = 0; i < 5; i++) begin
      op(0, 1, 8'h00, 3'(i), 1);
      st(0, 0, 1, 0, 4 - i);
    end
    for (int i = 0; i < 6; i++) begin
      op(1, 0, 8'h01 << ((5 + i) % 8), 3'd5, 0);
      st(1, 0, 0, 0, i + 1);
    end
    for (int i = 0; i < 6; i++) begin
      op(0, 1, 8'h00, 3'((5 + i) % 8), 1);
      st(0, 0, 1, 0, 5 - i);
    end

    // head = tail = 3, empty
    ph = "simul";
    for (int i = 0; i < 3; i++) begin
      op(1, 0, 8'h01 << (3 + i), 3'd3, 0);
      st(1, 0, 0, 0, i + 1);
    end
    for (int j = 0; j < 4; j++) begin
      op(1, 1, 8'h01 << ((6 + j) % 8), 3'((3 + j) % 8), 1);
      st(1, 0, 1, 0, 3);
    end
    // tail = 2, head = 7, count = 3; top up to full
    for (int i = 0; i < 5; i++) begin
      op(1, 0, 8'h01 << (2 + i), 3'd7, 0);
      st(1, 0, 0, 0, 4 + i);
    end

    ph = "full_both";
    op(1, 1, 8'h00, 3'd7, 1);
    st(0, 1, 1, 0, 7);
    for (int i = 0; i < 7; i++) begin
      op(0, 1, 8'h00, 3'(i), 1);
      st(0, 0, 1, 0, 6 - i);
    end

    ph = "empty_both";
    op(1, 1, 8'h80, 3'd7, 0);
    st(1, 0, 0, 1, 1);

    // tail = 0, head = 7, count = 1; bring count to 5 then reset
    ph = "mid_reset";
    for (int i = 0; i < 4; i++) begin
      op(1, 0, 8'h01 << i, 3'd7, 0);
      st(1, 0, 0, 0, 2 + i);
    end
    @(negedge clk);
    reset_n = 1'b0;
    wr_en   = 1'b1;
    #1;
    chk_eq("we_in_reset", {24'd0, we}, 32'd0);
    @(posedge clk);
    #1;
    st(0, 0, 0, 0, 0);
    chk_eq("rd_addr_reset", {29'd0, rd_addr}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    wr_en   = 1'b0;
    op(1, 0, 8'h01, 3'd0, 0);
    st(1, 0, 0, 0, 1);
    op(0, 1, 8'h00, 3'd0, 1);
    st(0, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
